data_mem_dump_ctrl: RTL and testbench
=====================================

Name: data_mem_dump_ctrl

Overview:
- Controller that shares the data memory between the pipeline MEM stage and the debug unit.
- On request, it waits for the pipeline to halt, takes the memory port, and reads every data memory word in order.
- Each word is streamed out byte by byte over a valid/ready interface to the debug unit's UART transmitter.
- It sits between the MEM stage and the memory's address/read/write/debug-flag inputs, replacing the static debug mux.

Parameters:
- NB_DATA, 32, data memory word width; must be a multiple of 8.
- NB_MEM_ADDR, 5, data memory address width; depth = 2**NB_MEM_ADDR words.
- NB_BYTE, 8, width of the transmit byte stream.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_dump_start  in  1  single-cycle request from the debug unit to dump memory.
- i_halt  in  1  pipeline halted (HALT instruction has reached MEM/WB).
- i_pipe_mem_read  in  1  MEM-stage read request.
- i_pipe_mem_write  in  1  MEM-stage write request.
- i_pipe_addr  in  NB_MEM_ADDR  MEM-stage word address (ALU result LSBs).
- i_mem_read_data  in  NB_DATA  data memory read port; valid one cycle after the address/read is presented.
- i_tx_ready  in  1  transmitter accepts a byte this cycle.
- o_mem_addr  out  NB_MEM_ADDR  address to data memory.
- o_mem_read  out  1  read enable to data memory.
- o_mem_write  out  1  write enable to data memory.
- o_debug_unit_flag  out  1  1 while the controller owns the memory port.
- o_tx_data  out  NB_BYTE  byte to transmit.
- o_tx_valid  out  1  o_tx_data is valid.
- o_busy  out  1  dump in progress (any state except IDLE).
- o_done  out  1  one-cycle pulse when the last byte has been accepted.

Behaviour:
- Reset (async, any state): state=IDLE, word_cnt=0, byte_cnt=0, shift register=0, o_tx_valid=0, o_tx_data=0, o_done=0.
  - o_busy=0 and o_debug_unit_flag=0, so the memory port returns to the pipeline.
  - Reset mid-dump aborts the dump with no o_done.
- FSM states: IDLE, WAIT_HALT, RD_REQ, RD_CAP, SEND, DONE.
- IDLE:
  - Memory port passes through combinationally: o_mem_addr=i_pipe_addr, o_mem_read=i_pipe_mem_read, o_mem_write=i_pipe_mem_write.
  - i_dump_start=1 -> WAIT_HALT.
- WAIT_HALT:
  - Port still passed through to the pipeline.
  - i_halt=1 -> RD_REQ with word_cnt=0.
  - i_dump_start while busy is ignored.
- RD_REQ:
  - o_debug_unit_flag=1, o_mem_addr=word_cnt, o_mem_read=1, o_mem_write=0.
  - Next cycle -> RD_CAP.
- RD_CAP:
  - o_debug_unit_flag=1, o_mem_read=1, address held.
  - Latch i_mem_read_data into the shift register; byte_cnt=0 -> SEND.
- SEND:
  - o_debug_unit_flag=1, o_mem_read=0, o_mem_write=0.
  - o_tx_valid=1; o_tx_data = shift register MSB byte (big-endian, byte 3 first for NB_DATA=32).
  - Transfer occurs when o_tx_valid and i_tx_ready are both 1. On transfer: shift left by NB_BYTE, byte_cnt+1.
  - o_tx_data and o_tx_valid hold stable while i_tx_ready=0; no timeout.
  - Transfer of byte NB_DATA/8-1:
    - if word_cnt = 2**NB_MEM_ADDR-1 -> DONE;
    - else word_cnt+1 -> RD_REQ.
  - o_tx_valid deasserts in the following RD_REQ/RD_CAP cycles.
- DONE:
  - o_done=1 for exactly one cycle, o_debug_unit_flag=0, o_tx_valid=0.
  - Next cycle -> IDLE with word_cnt=0.
- Arbitration:
  - While o_debug_unit_flag=1, pipeline requests are dropped; o_mem_write is forced 0, so there is no corruption of dumped data.
  - i_halt deasserting mid-dump is ignored; the dump completes.
  - i_dump_start coincident with reset: reset wins.
- Word counter is NB_MEM_ADDR bits wide; the final word is detected explicitly, with no reliance on wrap-around.
- Throughput: 2 + (NB_DATA/8) cycles per word with i_tx_ready tied high.
  - Full dump at defaults with ready tied high: 32*6 = 192 cycles from first RD_REQ to last transfer, plus 1 DONE cycle.

Test Plan:
- Memory preloaded with word k = 32'hA0B0C000+k; i_tx_ready=1; pulse i_dump_start with i_halt=1.
  - Required: exactly 128 bytes A0,B0,C0,00,A0,B0,C0,01,…,A0,B0,C0,1F.
  - Required: o_done pulses one cycle after the last transfer, then o_busy=0.
- i_dump_start with i_halt=0 for 10 cycles, then i_halt=1.
  - Required: no o_debug_unit_flag and port passthrough during the wait (i_pipe_addr=5'd7, read=1 -> o_mem_addr=7, o_mem_read=1).
  - Required: first RD_REQ occurs the cycle after i_halt rises.
- i_tx_ready toggled 0/1 pseudo-randomly.
  - Required: o_tx_data stable whenever valid && !ready; byte sequence identical to the first scenario.
- During the dump, drive i_pipe_mem_write=1, i_pipe_addr=3.
  - Required: o_mem_write stays 0; word 3 is still dumped as A0B0C003.
- Assert i_reset during SEND of word 10.
  - Required: same-cycle o_tx_valid=0, o_debug_unit_flag=0, o_busy=0, no o_done.
  - Required: a subsequent dump restarts at word 0.
- Second i_dump_start pulse mid-dump.
  - Required: ignored; exactly one 128-byte stream and one o_done.

Source files
------------

// File: rtl/data_mem_dump_ctrl.sv
// Data memory dump controller: shares the data memory port between the
// pipeline MEM stage and the debug unit. On request it waits for the pipeline
// to halt, then reads every word in order and streams it out MSB byte first
// over a valid/ready byte interface.
module data_mem_dump_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_MEM_ADDR = 5,
  parameter int NB_BYTE     = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_dump_start,
  input  logic                   i_halt,
  input  logic                   i_pipe_mem_read,
  input  logic                   i_pipe_mem_write,
  input  logic [NB_MEM_ADDR-1:0] i_pipe_addr,
  input  logic [NB_DATA-1:0]     i_mem_read_data,
  input  logic                   i_tx_ready,
  output logic [NB_MEM_ADDR-1:0] o_mem_addr,
  output logic                   o_mem_read,
  output logic                   o_mem_write,
  output logic                   o_debug_unit_flag,
  output logic [NB_BYTE-1:0]     o_tx_data,
  output logic                   o_tx_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int BCW     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [BCW-1:0]         LAST_BYTE = BCW'(N_BYTES - 1);
  localparam logic [NB_MEM_ADDR-1:0] LAST_WORD = {NB_MEM_ADDR{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
    RD_REQ,
    RD_CAP,
    SEND,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [NB_MEM_ADDR-1:0] word_cnt_q, word_cnt_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0]     shift_q, shift_d;

  // State, counters and shift register; reset aborts any dump in progress.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

  // Next-state logic and memory-port arbitration: the pipeline owns the port
  // unless the controller is actively reading or sending (flag high), in
  // which case pipeline requests are dropped and writes are blocked.
  always_comb begin
    state_d           = state_q;
    word_cnt_d        = word_cnt_q;
    byte_cnt_d        = byte_cnt_q;
    shift_d           = shift_q;
    o_mem_addr        = i_pipe_addr;
    o_mem_read        = i_pipe_mem_read;
    o_mem_write       = i_pipe_mem_write;
    o_debug_unit_flag = 1'b0;
    o_tx_valid        = 1'b0;
    o_done            = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dump_start) state_d = WAIT_HALT;
      end
      WAIT_HALT: begin
        if (i_halt) begin
          state_d    = RD_REQ;
          word_cnt_d = '0;
        end
      end
      RD_REQ: begin
        o_debug_unit_flag = 1'b1;
        o_mem_addr        = word_cnt_q;
        o_mem_read        = 1'b1;
        o_mem_write       = 1'b0;
        state_d           = RD_CAP;
      end
      RD_CAP: begin
        o_debug_unit_flag = 1'b1;
        o_mem_addr        = word_cnt_q;
        o_mem_read        = 1'b1;
        o_mem_write       = 1'b0;
        shift_d           = i_mem_read_data;
        byte_cnt_d        = '0;
        state_d           = SEND;
      end
      SEND: begin
        o_debug_unit_flag = 1'b1;
        o_mem_addr        = word_cnt_q;
        o_mem_read        = 1'b0;
        o_mem_write       = 1'b0;
        o_tx_valid        = 1'b1;
        if (i_tx_ready) begin
          shift_d    = shift_q << NB_BYTE;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            // Last word is detected explicitly rather than by counter wrap.
            if (word_cnt_q == LAST_WORD) begin
              state_d = DONE;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              state_d    = RD_REQ;
            end
          end
        end
      end
      DONE: begin
        o_done     = 1'b1;
        word_cnt_d = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit byte is always the top byte of the shift register (big-endian).
  assign o_tx_data = shift_q[NB_DATA-1 -: NB_BYTE];
  assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// Self-checking bench for data_mem_dump_ctrl: table-driven passthrough
// vectors, randomized passthrough/ready stimulus, and full dump sequences
// compared against an expected byte queue built from the memory contents.
module tb_data_mem_dump_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_dump_start, i_halt;
  logic        i_pipe_mem_read, i_pipe_mem_write;
  logic [4:0]  i_pipe_addr;
  logic [31:0] i_mem_read_data;
  logic        i_tx_ready;
  logic [4:0]  o_mem_addr;
  logic        o_mem_read, o_mem_write, o_debug_unit_flag;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid, o_busy, o_done;

  data_mem_dump_ctrl dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_dump_start     (i_dump_start),
    .i_halt           (i_halt),
    .i_pipe_mem_read  (i_pipe_mem_read),
    .i_pipe_mem_write (i_pipe_mem_write),
    .i_pipe_addr      (i_pipe_addr),
    .i_mem_read_data  (i_mem_read_data),
    .i_tx_ready       (i_tx_ready),
    .o_mem_addr       (o_mem_addr),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_debug_unit_flag(o_debug_unit_flag),
    .o_tx_data        (o_tx_data),
    .o_tx_valid       (o_tx_valid),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read data memory preloaded with word k = A0B0C000 + k.
  always @(posedge clk) begin
    if (o_mem_read) i_mem_read_data <= 32'hA0B0C000 + 32'(o_mem_addr);
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected byte stream of one full dump.
  logic [7:0] exp_q[$];
  task automatic load_expected();
    logic [31:0] w;
    exp_q.delete();
    for (int k = 0; k < 32; k++) begin
      w = 32'hA0B0C000 + 32'(k);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  bit rand_ready = 0;
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) i_tx_ready = 1'($urandom_range(0, 1));
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int xfer_cnt = 0, done_cnt = 0, last_xfer_cyc = 0, first_req_cyc = 0;
  bit hold_v = 0, flag_prev = 0;
  logic [7:0] hold_d = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (i_reset) begin
        hold_v = 0;
      end else begin
        if (hold_v) begin
          check("hold_valid", 32'(o_tx_valid), 32'd1);
          check("hold_data", 32'(o_tx_data), 32'(hold_d));
        end
        hold_v = o_tx_valid && !i_tx_ready;
        hold_d = o_tx_data;
        if (o_debug_unit_flag) check("no_write_while_owned", 32'(o_mem_write), 32'd0);
        if (o_tx_valid && i_tx_ready) begin
          xfer_cnt++;
          last_xfer_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL extra_byte: got %h expected no transfer", o_tx_data);
          end else begin
            check("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
          end
        end
        if (o_done) begin
          done_cnt++;
          check("done_after_last_xfer", 32'(cyc - last_xfer_cyc), 32'd1);
          check("done_all_bytes_sent", 32'(exp_q.size()), 32'd0);
        end
        if (o_debug_unit_flag && !flag_prev) first_req_cyc = cyc;
        flag_prev = o_debug_unit_flag;
      end
    end
  end

  // Full dump: optional random ready, second start pulse, pipeline write noise.
  task automatic run_dump(input bit rr, input bit second_pulse, input bit pipe_wr);
    int x0, d0;
    bit got;
    load_expected();
    x0 = xfer_cnt;
    d0 = done_cnt;
    got = 0;
    i_halt = 1;
    i_tx_ready = 1;
    rand_ready = rr;
    i_dump_start = 1;
    step();
    i_dump_start = 0;
    if (pipe_wr) begin
      i_pipe_mem_write = 1;
      i_pipe_addr = 5'd3;
    end
    for (int i = 0; i < 2000 && !got; i++) begin
      step();
      i_dump_start = (second_pulse && i == 60) ? 1'b1 : 1'b0;
      if (o_done) got = 1;
    end
    i_pipe_mem_write = 0;
    i_dump_start = 0;
    rand_ready = 0;
    i_tx_ready = 1;
    check("dump_completed", 32'(got), 32'd1);
    check("dump_byte_count", 32'(xfer_cnt - x0), 32'd128);
    if (!rr) check("dump_length_cycles", 32'(last_xfer_cyc - first_req_cyc), 32'd191);
    step();
    check("busy_after_done", 32'(o_busy), 32'd0);
    repeat (10) step();
    check("single_done_pulse", 32'(done_cnt - d0), 32'd1);
    check("still_idle", 32'(o_busy), 32'd0);
  endtask

  typedef struct {
    logic [4:0] addr;
    logic       rd;
    logic       wr;
    logic [4:0] exp_addr;
    logic       exp_rd;
    logic       exp_wr;
    logic       exp_flag;
  } pt_vec_t;

  pt_vec_t vecs[4];

  initial begin
    int d0;
    bit got;
    logic [4:0] ra;
    logic rr, rw;

    vecs[0] = '{5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{5'd31, 1'b0, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{5'd18, 1'b1, 1'b1, 5'd18, 1'b1, 1'b1, 1'b0};

    i_reset = 1; i_dump_start = 1; i_halt = 1;
    i_pipe_mem_read = 0; i_pipe_mem_write = 0; i_pipe_addr = '0;
    i_tx_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_flag", 32'(o_debug_unit_flag), 32'd0);
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    i_dump_start = 0;
    i_reset = 0;
    step();
    check("start_with_reset_ignored", 32'(o_busy), 32'd0);

    // Table-driven passthrough vectors in IDLE.
    for (int i = 0; i < 4; i++) begin
      i_pipe_addr = vecs[i].addr;
      i_pipe_mem_read = vecs[i].rd;
      i_pipe_mem_write = vecs[i].wr;
      #1;
      check("pt_addr", 32'(o_mem_addr), 32'(vecs[i].exp_addr));
      check("pt_read", 32'(o_mem_read), 32'(vecs[i].exp_rd));
      check("pt_write", 32'(o_mem_write), 32'(vecs[i].exp_wr));
      check("pt_flag", 32'(o_debug_unit_flag), 32'(vecs[i].exp_flag));
    end

    // Randomized passthrough in IDLE: port must mirror the pipeline.
    for (int i = 0; i < 16; i++) begin
      ra = 5'($urandom_range(0, 31));
      rr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      i_pipe_addr = ra; i_pipe_mem_read = rr; i_pipe_mem_write = rw;
      #1;
      check("rnd_pt", {25'd0, o_mem_addr, o_mem_read, o_mem_write}, {25'd0, ra, rr, rw});
      step();
    end
    i_pipe_mem_read = 0; i_pipe_mem_write = 0; i_pipe_addr = '0;

    // Basic dump, ready tied high.
    run_dump(0, 0, 0);

    // Halt arrives late: port stays with the pipeline while waiting.
    load_expected();
    d0 = done_cnt;
    i_halt = 0;
    i_pipe_addr = 5'd7;
    i_pipe_mem_read = 1;
    i_dump_start = 1;
    step();
    i_dump_start = 0;
    for (int i = 0; i < 10; i++) begin
      check("wait_flag", 32'(o_debug_unit_flag), 32'd0);
      check("wait_addr", 32'(o_mem_addr), 32'd7);
      check("wait_read", 32'(o_mem_read), 32'd1);
      check("wait_busy", 32'(o_busy), 32'd1);
      step();
    end
    i_halt = 1;
    step();
    check("rdreq_flag", 32'(o_debug_unit_flag), 32'd1);
    check("rdreq_addr", 32'(o_mem_addr), 32'd0);
    check("rdreq_read", 32'(o_mem_read), 32'd1);
    i_pipe_mem_read = 0;
    i_pipe_addr = '0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (o_done) got = 1;
    end
    check("late_halt_done", 32'(got), 32'd1);
    step();
    check("late_halt_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Random backpressure with pipeline writes to address 3 during the dump.
    run_dump(1, 0, 1);

    // Second start pulse mid-dump is ignored.
    run_dump(0, 1, 0);

    // Reset during SEND of word 10 aborts without done.
    load_expected();
    d0 = done_cnt;
    i_halt = 1;
    i_dump_start = 1;
    step();
    i_dump_start = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (xfer_cnt % 128 == 41 % 128 && o_tx_valid) got = 1;
    end
    check("reached_word10", 32'(got), 32'd1);
    i_tx_ready = 0;
    #1;
    check("word10_valid", 32'(o_tx_valid), 32'd1);
    check("word10_byte1", 32'(o_tx_data), 32'hB0);
    i_reset = 1;
    #1;
    check("abort_valid", 32'(o_tx_valid), 32'd0);
    check("abort_flag", 32'(o_debug_unit_flag), 32'd0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    repeat (2) step();
    i_reset = 0;
    exp_q.delete();
    step();
    check("abort_no_done_pulse", 32'(done_cnt - d0), 32'd0);

    // Dump after abort restarts at word 0.
    run_dump(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
